mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 4-cycle pipelined memory between the I-cache and D-cache fill FSMs.
//  Grants ownership for a whole block fill (8 word reads) or one write-through word.
//  Steers the owner's address/control to memory and returns read data/valid to the owner only.
//  Stalls the loser. Sits between both CACHE instances and the memory model in the top level.
// PARAMETERS
//  ADDR_W     16  address width
//  DATA_W     16  data word width
//  MEM_LAT    4   memory read latency, cycles from issue to data valid
//  OUTST_W    3   outstanding-read counter width; must hold MEM_LAT
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  i_mem_read       in   1       I-cache fill FSM read request (cache_MemRead)
//  i_mem_addr       in   ADDR_W  I-cache memory address
//  i_busy           in   1       I-cache fill FSM busy (CacheBusy)
//  d_mem_read       in   1       D-cache fill FSM read request
//  d_mem_write      in   1       D-cache write-through request (cache_MemWrite)
//  d_mem_addr       in   ADDR_W  D-cache memory address
//  d_mem_wdata      in   DATA_W  D-cache write data
//  d_busy           in   1       D-cache fill FSM busy
//  mem_rdata        in   DATA_W  memory read data
//  mem_data_valid   in   1       memory read data valid
//  mem_enable       out  1       memory access strobe
//  mem_wr           out  1       1 = write, 0 = read
//  mem_addr         out  ADDR_W  memory address
//  mem_wdata        out  DATA_W  memory write data
//  i_data_valid     out  1       mem_data_valid gated to I-cache
//  d_data_valid     out  1       mem_data_valid gated to D-cache
//  rdata            out  DATA_W  mem_rdata broadcast to both caches
//  i_stall          out  1       I-cache request pending, not granted
//  d_stall          out  1       D-cache request pending, not granted
//  err              out  1       sticky: mem_data_valid seen with zero outstanding reads
// BEHAVIOUR
//  Reset: state IDLE, last_grant=I, outstanding=0, err=0; all outputs 0 (rdata follows mem_rdata).
//  Requests: i_req = i_mem_read|i_busy; d_req = d_mem_read|d_busy|d_mem_write.
//  States: IDLE, I_FILL, D_FILL, D_WRITE, DRAIN.
//  IDLE: no memory access. Arbitrate; new state registered, 1-cycle arbitration latency.
//   One request -> grant it. Both -> grant the side opposite last_grant (round robin).
//   D grant: d_mem_write -> D_WRITE, else D_FILL. Update last_grant on every grant.
//  D_WRITE: one cycle. mem_enable=1, mem_wr=1, addr/wdata from D. -> IDLE.
//  I_FILL/D_FILL: mem_enable=owner's mem_read, mem_wr=0, mem_addr=owner addr.
//   Owner busy=0 -> DRAIN.
//  DRAIN: no new issue. outstanding==0 -> IDLE.
//  Same-cycle drain exit: owner busy=0 with outstanding==0 goes straight to IDLE.
//  Outstanding counter: +1 per issued read (mem_enable & ~mem_wr); -1 per mem_data_valid.
//   Both in one cycle -> unchanged. Saturates at MEM_LAT, never below 0.
//   Decrement at 0 sets err and is ignored.
//  Data return: {i,d}_data_valid = mem_data_valid & (owner==I / owner==D).
//   Owner is the last granted fill side, held through DRAIN.
//  Stall (combinational): x_stall = x_req & ~(state grants x).
//   Asserted in IDLE too, including the arbitration cycle.
//  D-cache write-through request during an I fill: stalled until IDLE, then arbitrated.
//   Writes are never merged into a fill.
//  Reset mid-fill: return to IDLE, outstanding cleared.
//   Returning data is dropped; err is not set for that data, cleared by reset.
// STRUCTURE
//  Shared package mem_arb_pkg: state encoding localparams (IDLE..DRAIN), GRANT_I/GRANT_D, MEM_LAT.
//  One sub-module: mem_outstanding_ctr (inc, dec, count, zero, underflow) for reuse by the memory model.
//  FSM, steering muxes and stall logic stay in the top module.
// TESTING
//  I-only fill, addr 0x0040: 8 reads issued, 8 i_data_valid pulses, d_data_valid=0; IDLE 1 cycle after last data.
//  D and I request in same IDLE cycle after reset: D granted (last_grant=I); i_stall=1 until D DRAIN->IDLE; then I granted.
//  D write 0x1234 to 0x0100 during I fill:
//   d_stall=1 through the fill; then exactly one cycle mem_wr=1, addr 0x0100, wdata 0x1234.
//  Back-to-back: I done, D pending, I re-requests same cycle: D granted (round robin), not I.
//  rst_n low on 2nd in-flight read: outputs 0 immediately; data returning later gives no *_data_valid, err=0.
//  Spurious mem_data_valid in IDLE: err=1 and stays 1; counter stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter and its
// outstanding-read counter.
package mem_arb_pkg;

  localparam int MEM_LAT = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_FILL  = 3'd1,
    D_FILL  = 3'd2,
    D_WRITE = 3'd3,
    DRAIN   = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_outstanding_ctr.sv
// Outstanding-read counter: +1 per issue, -1 per returned word, saturating at
// MAX, flags a return seen while nothing is outstanding.
module mem_outstanding_ctr #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         underflow
);

  logic eff_dec;

  assign zero      = (count == '0);
  assign underflow = dec & zero;
  // A return at zero is discarded, so only a decrement with something in flight counts.
  assign eff_dec   = dec & ~zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !eff_dec) begin
      if (count != W'(MAX)) count <= count + 1'b1;
    end else if (eff_dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared pipelined memory between the I-cache and D-cache fill
// FSMs: whole-block fills or single write-through words, round robin on ties.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = mem_arb_pkg::MEM_LAT,
  parameter int OUTST_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              i_busy,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  input  logic              d_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              i_stall,
  output logic              d_stall,
  output logic              err
);

  import mem_arb_pkg::*;

  arb_state_t         state;
  grant_t             last_grant;
  grant_t             owner;
  logic [OUTST_W-1:0] blank;
  logic [OUTST_W-1:0] outst;
  logic               outst_zero;
  logic               underflow;
  logic               i_req, d_req;
  logic               issue, dec, drained, fill_active;

  assign i_req = i_mem_read | i_busy;
  assign d_req = d_mem_read | d_busy | d_mem_write;

  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      I_FILL: begin
        mem_enable = i_mem_read;
        mem_addr   = i_mem_addr;
      end
      D_FILL: begin
        mem_enable = d_mem_read;
        mem_addr   = d_mem_addr;
      end
      D_WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_mem_addr;
        mem_wdata  = d_mem_wdata;
      end
      default: ;
    endcase
  end

  assign i_stall = rst_n & i_req & (state != I_FILL);
  assign d_stall = rst_n & d_req & (state != D_FILL) & (state != D_WRITE);

  // Reads issued before a reset can still come back for MEM_LAT cycles after it;
  // those words are swallowed without counting or flagging err.
  assign dec         = mem_data_valid & (blank == '0);
  assign issue       = mem_enable & ~mem_wr;
  assign drained     = (outst_zero || (outst == OUTST_W'(1) && dec)) && !issue;
  assign fill_active = (state == I_FILL) || (state == D_FILL) || (state == DRAIN);

  assign i_data_valid = dec & fill_active & (owner == GRANT_I);
  assign d_data_valid = dec & fill_active & (owner == GRANT_D);
  assign rdata        = mem_rdata;

  mem_outstanding_ctr #(
    .MAX (MEM_LAT),
    .W   (OUTST_W)
  ) u_outst (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (issue),
    .dec       (dec),
    .count     (outst),
    .zero      (outst_zero),
    .underflow (underflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      owner      <= GRANT_I;
      blank      <= OUTST_W'(MEM_LAT);
      err        <= 1'b0;
    end else begin
      if (blank != '0) blank <= blank - 1'b1;
      if (underflow) err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_req && (!d_req || last_grant == GRANT_D)) begin
            state      <= I_FILL;
            last_grant <= GRANT_I;
            owner      <= GRANT_I;
          end else if (d_req) begin
            last_grant <= GRANT_D;
            if (d_mem_write) begin
              state <= D_WRITE;
            end else begin
              state <= D_FILL;
              owner <= GRANT_D;
            end
          end
        end
        D_WRITE: state <= IDLE;
        I_FILL:  if (!i_busy) state <= drained ? IDLE : DRAIN;
        D_FILL:  if (!d_busy) state <= drained ? IDLE : DRAIN;
        DRAIN:   if (drained) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reactive cache drivers, a 4-cycle memory pipeline and
// a transaction-level reference model checked on every falling clock edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_mem_read = 1'b0, i_busy = 1'b0;
  logic [15:0] i_mem_addr = '0;
  logic        d_mem_read = 1'b0, d_mem_write = 1'b0, d_busy = 1'b0;
  logic [15:0] d_mem_addr = '0, d_mem_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;
  logic        mem_enable, mem_wr, i_data_valid, d_data_valid, i_stall, d_stall, err;
  logic [15:0] mem_addr, mem_wdata, rdata;

  int n_pass = 0, n_total = 0, cyc = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4), .OUTST_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr), .i_busy(i_busy),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_busy(d_busy),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid), .rdata(rdata),
    .i_stall(i_stall), .d_stall(d_stall), .err(err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory: read data appears 4 cycles after issue; not reset, so in-flight reads survive rst_n.
  logic [3:0]  pv = '0;
  logic [15:0] pd [4] = '{default: '0};
  logic        spur = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_enable & ~mem_wr};
    pd[0] <= mem_addr ^ 16'h5A5A;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end
  assign mem_data_valid = pv[3] | spur;
  assign mem_rdata      = pd[3];

  // Reference model: tenure owner plus a queue of in-flight reads tagged 1=I, 2=D, 0=stale.
  int  q[$];
  int  m_owner = 0, m_last = 1;
  bit  m_write = 0, m_drain = 0, m_err = 0;
  bit  e_issue = 0;
  int  e_tag = 0;

  always @(posedge clk) begin : model
    int  live, pick;
    bit  ireq, dreq;
    ireq = i_mem_read | i_busy;
    dreq = d_mem_read | d_busy | d_mem_write;
    if (!rst_n) begin
      m_owner = 0; m_write = 0; m_drain = 0; m_last = 1; m_err = 0;
      foreach (q[k]) q[k] = 0;
    end
    if (mem_data_valid) begin
      if (q.size() == 0) begin
        if (rst_n) m_err = 1;
      end else q.delete(0);
    end
    if (rst_n && e_issue) q.push_back(e_tag);
    live = 0;
    foreach (q[k]) if (q[k] != 0) live++;
    if (rst_n) begin
      if (m_write) m_write = 0;
      else if (m_owner == 0) begin
        pick = 0;
        if (ireq && dreq) pick = (m_last == 1) ? 2 : 1;
        else if (ireq) pick = 1;
        else if (dreq) pick = 2;
        if (pick != 0) begin
          m_last = pick;
          if (pick == 2 && d_mem_write) m_write = 1;
          else m_owner = pick;
        end
      end else if (!m_drain && !((m_owner == 1) ? i_busy : d_busy)) begin
        if (live == 0) m_owner = 0;
        else m_drain = 1;
      end else if (m_drain && live == 0) begin
        m_owner = 0;
        m_drain = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit i_serv, d_serv, ireq, dreq, en, wr, idv, ddv;
    logic [15:0] addr, wd;
    int head;
    ireq = i_mem_read | i_busy;
    dreq = d_mem_read | d_busy | d_mem_write;
    i_serv = rst_n && m_owner == 1 && !m_drain;
    d_serv = rst_n && ((m_owner == 2 && !m_drain) || m_write);
    en = 0; wr = 0; addr = '0; wd = '0;
    if (rst_n && m_write) begin
      en = 1; wr = 1; addr = d_mem_addr; wd = d_mem_wdata;
    end else if (i_serv) begin
      en = i_mem_read; addr = i_mem_addr;
    end else if (d_serv) begin
      en = d_mem_read; addr = d_mem_addr;
    end
    head = (q.size() != 0) ? q[0] : -1;
    idv = rst_n && mem_data_valid && head == 1;
    ddv = rst_n && mem_data_valid && head == 2;
    e_issue = en && !wr;
    e_tag   = i_serv ? 1 : 2;
    chk("mem_enable", mem_enable, en);
    chk("mem_wr", mem_wr, wr);
    chk("mem_addr", mem_addr, addr);
    chk("mem_wdata", mem_wdata, wd);
    chk("i_stall", i_stall, rst_n && ireq && !i_serv);
    chk("d_stall", d_stall, rst_n && dreq && !d_serv);
    chk("i_data_valid", i_data_valid, idv);
    chk("d_data_valid", d_data_valid, ddv);
    chk("rdata", rdata, pd[3]);
    chk("err", err, rst_n && m_err);
  end

  // Cache drivers: hold the request, advance the address on each accepted read.
  int i_left = 0, d_left = 0, i_issued = 0;
  int i_dv_cnt = 0, d_dv_cnt = 0, wr_cnt = 0;
  int i_first = -1, d_first = -1, i_last = 0, d_last = 0, wr_cyc = 0;
  logic [15:0] i_first_data = '0, wr_addr = '0, wr_data = '0;

  initial forever begin
    bit i_took, d_took, dw_took;
    @(negedge clk);
    i_took  = rst_n && i_mem_read && !i_stall;
    d_took  = rst_n && d_mem_read && !d_stall;
    dw_took = rst_n && d_mem_write && !d_stall;
    if (i_data_valid) begin
      i_dv_cnt++;
      i_last = cyc;
      if (i_dv_cnt == 1) i_first_data = rdata;
    end
    if (d_data_valid) begin
      d_dv_cnt++;
      d_last = cyc;
    end
    if (i_took) begin
      i_issued++;
      if (i_first < 0) i_first = cyc;
    end
    if (d_took && d_first < 0) d_first = cyc;
    if (mem_enable && mem_wr) begin
      wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; wr_cyc = cyc;
    end
    @(posedge clk);
    #2;
    if (i_took && rst_n) begin
      i_left--;
      i_mem_addr = i_mem_addr + 16'd1;
      if (i_left == 0) begin i_busy = 0; i_mem_read = 0; end
    end
    if (d_took && rst_n) begin
      d_left--;
      d_mem_addr = d_mem_addr + 16'd1;
      if (d_left == 0) begin d_busy = 0; d_mem_read = 0; end
    end
    if (dw_took) d_mem_write = 0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic i_start(input logic [15:0] a);
    i_mem_addr = a; i_left = 8; i_first = -1; i_busy = 1; i_mem_read = 1;
  endtask

  task automatic d_fill(input logic [15:0] a);
    d_mem_addr = a; d_left = 8; d_first = -1; d_busy = 1; d_mem_read = 1;
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0: return i_dv_cnt;
      1: return d_dv_cnt;
      2: return wr_cnt;
      default: return i_issued;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, input string name);
    int n = 0;
    while (get_cnt(which) < target && n < budget) begin step(1); n++; end
    chk(name, get_cnt(which) >= target, 1);
  endtask

  initial begin
    int i_last_a, dv_snap;
    #1 rst_n = 0;
    step(2);
    chk("reset mem_enable", mem_enable, 0);
    chk("reset err", err, 0);
    chk("reset data_valid", {i_data_valid, d_data_valid}, 0);
    rst_n = 1;
    step(8);

    // I-only fill from 0x0040
    i_start(16'h0040);
    wait_for(0, 8, 60, "t1 i fill timeout");
    chk("t1 i_dv count", i_dv_cnt, 8);
    chk("t1 d_dv count", d_dv_cnt, 0);
    chk("t1 reads issued", i_issued, 8);
    chk("t1 first data", i_first_data, 16'h5A1A);
    chk("t1 idle one cycle after data", cyc - i_last, 1);

    // Both request in that IDLE cycle; last grant was I so D wins
    i_dv_cnt = 0; d_dv_cnt = 0;
    i_start(16'h0200); d_fill(16'h0300);
    #1;
    chk("t2 arb i_stall", i_stall, 1);
    chk("t2 arb d_stall", d_stall, 1);
    step(1);
    chk("t2 d granted", d_stall, 0);
    chk("t2 i stalled", i_stall, 1);
    chk("t2 d addr", mem_addr, 16'h0300);
    wait_for(1, 8, 60, "t2 d fill timeout");
    wait_for(0, 8, 60, "t2 i fill timeout");
    chk("t2 i starts after d idle", i_first - d_last, 2);

    // D write-through during an I fill waits for IDLE
    step(2);
    i_dv_cnt = 0; wr_cnt = 0;
    i_start(16'h0400);
    step(3);
    d_mem_addr = 16'h0100; d_mem_wdata = 16'h1234; d_mem_write = 1;
    #1;
    chk("t3 d_stall in fill", d_stall, 1);
    wait_for(0, 8, 60, "t3 i fill timeout");
    wait_for(2, 1, 10, "t3 write timeout");
    step(3);
    chk("t3 write count", wr_cnt, 1);
    chk("t3 write addr", wr_addr, 16'h0100);
    chk("t3 write data", wr_data, 16'h1234);
    chk("t3 write after idle", wr_cyc - i_last, 2);

    // I finishes with D pending and re-requests in the same IDLE cycle: D wins
    i_dv_cnt = 0; d_dv_cnt = 0;
    i_start(16'h0500);
    step(2);
    d_fill(16'h0600);
    wait_for(0, 8, 60, "t4 i fill timeout");
    i_last_a = i_last;
    i_start(16'h0520);
    wait_for(1, 8, 60, "t4 d fill timeout");
    chk("t4 d granted first", d_first - i_last_a, 2);
    wait_for(0, 16, 60, "t4 i refill timeout");
    chk("t4 i after d", i_first - d_last, 2);

    // Reset with reads in flight
    step(2);
    i_issued = 0; i_dv_cnt = 0;
    i_start(16'h0700);
    wait_for(3, 2, 20, "t5 issue timeout");
    rst_n = 0;
    #1;
    chk("t5 reset mem_enable", mem_enable, 0);
    chk("t5 reset i_stall", i_stall, 0);
    chk("t5 reset mem_addr", mem_addr, 0);
    i_busy = 0; i_mem_read = 0; i_left = 0;
    dv_snap = i_dv_cnt;
    step(1);
    rst_n = 1;
    step(8);
    chk("t5 stale data dropped", i_dv_cnt, dv_snap);
    chk("t5 err after stale data", err, 0);

    // Spurious return in IDLE
    spur = 1;
    step(1);
    spur = 0;
    chk("t6 err set", err, 1);
    step(4);
    chk("t6 err sticky", err, 1);
    i_dv_cnt = 0;
    i_start(16'h0800);
    wait_for(0, 8, 60, "t6 i fill timeout");
    step(2);
    chk("t6 err still set", err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
